// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the sobel datapath: admits one frame of windows, aligns results.
// Optional edge counter enabled by defining SOBEL_CTRL_EDGE_CNT_EN.
module sobel_frame_ctrl #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int LATENCY = 7,
    parameter int THRESH  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           refresh,
    input  logic [7:0]     filt_pix,
    output logic [7:0]     out_pix,
    output logic           out_valid,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           busy,
`ifdef SOBEL_CTRL_EDGE_CNT_EN
    output logic [X_W+Y_W-1:0] edge_count,
`endif
    output logic           frame_done
);

    localparam int FW = $clog2(LATENCY + 1);
    localparam logic [X_W-1:0] XMAX = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] YMAX = Y_W'(HEIGHT - 1);
    localparam logic [FW-1:0]  LAT_C = FW'(LATENCY);

    if (THRESH > 255 || (2 ** X_W) < WIDTH || (2 ** Y_W) < HEIGHT) begin : g_param_chk
        $error("sobel_frame_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REFRESH,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [FW-1:0]  fcnt_q;
    logic           in_ready_q;
    logic           refresh_q;
    logic           busy_q;
    logic           done_q;
    logic           accept;

    assign accept     = in_valid && in_ready_q;
    assign in_ready   = in_ready_q;
    assign refresh    = refresh_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            fcnt_q     <= '0;
            in_ready_q <= 1'b0;
            refresh_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            refresh_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_REFRESH;
                        refresh_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_REFRESH: begin
                    x_q        <= '0;
                    y_q        <= '0;
                    state_q    <= S_RUN;
                    in_ready_q <= 1'b1;
                end
                S_RUN: begin
                    if (accept) begin
                        if (x_q == XMAX) begin
                            x_q <= '0;
                            if (y_q == YMAX) begin
                                state_q    <= S_FLUSH;
                                in_ready_q <= 1'b0;
                                fcnt_q     <= '0;
                            end else begin
                                y_q <= y_q + 1'b1;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                // Stay until the final result has left the output register.
                S_FLUSH: begin
                    if (fcnt_q == LAT_C) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q   <= S_REFRESH;
                        refresh_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic           vld_q [LATENCY];
    logic [X_W-1:0] dx_q  [LATENCY];
    logic [Y_W-1:0] dy_q  [LATENCY];
    logic           tap_v;
    logic [X_W-1:0] tap_x;
    logic [Y_W-1:0] tap_y;
    logic           border;
    logic           ov_q;
    logic [7:0]     pix_q;
    logic [X_W-1:0] ox_q;
    logic [Y_W-1:0] oy_q;

    assign tap_v  = vld_q[LATENCY-1];
    assign tap_x  = dx_q[LATENCY-1];
    assign tap_y  = dy_q[LATENCY-1];
    assign border = (tap_x == '0) || (tap_x == XMAX) ||
                    (tap_y == '0) || (tap_y == YMAX);

    assign out_valid = ov_q;
    assign out_pix   = pix_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dx_q[i]  <= '0;
                dy_q[i]  <= '0;
            end
            ov_q  <= 1'b0;
            pix_q <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            vld_q[0] <= accept;
            dx_q[0]  <= x_q;
            dy_q[0]  <= y_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dx_q[i]  <= dx_q[i-1];
                dy_q[i]  <= dy_q[i-1];
            end
            ov_q  <= tap_v;
            ox_q  <= tap_x;
            oy_q  <= tap_y;
            pix_q <= border ? 8'h00 : filt_pix;
        end
    end

`ifdef SOBEL_CTRL_EDGE_CNT_EN
    logic [X_W+Y_W-1:0] ec_q;

    assign edge_count = ec_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ec_q <= '0;
        end else if (state_q == S_REFRESH) begin
            ec_q <= '0;
        end else if (tap_v && !border && filt_pix >= 8'(THRESH)) begin
            ec_q <= ec_q + 1'b1;
        end
    end
`endif

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Frame sequencer for the sobelfilter datapath; sits between the 3x3 window source and downstream pixel sink.
- Issues the per-frame refresh pulse and admits exactly WIDTH*HEIGHT windows per frame.
- Tracks the filter's fixed pipeline latency with a valid shift register, then tags each filter output with its x/y coordinates.
- Forces border outputs to 0 and drains the pipeline before signalling frame completion.

Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- X_W, 10, x-coordinate width; must satisfy 2^X_W >= WIDTH
- Y_W, 9, y-coordinate width; must satisfy 2^Y_W >= HEIGHT
- LATENCY, 7, cycles from a window on the filter inputs to its result on filter out
- THRESH, 64, edge threshold, used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  request to begin a frame
- in_valid  in  1  upstream window on the filter inputs is valid this cycle
- in_ready  out  1  controller accepts a window this cycle
- refresh  out  1  to sobelfilter refresh, one-cycle pulse
- filt_pix  in  8  sobelfilter out
- out_pix  out  8  masked result pixel
- out_valid  out  1  out_pix/out_x/out_y valid
- out_x  out  X_W  column of out_pix
- out_y  out  Y_W  row of out_pix
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse when the frame is fully drained

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE; all counters and the valid shift register are cleared.
  - Outputs after reset: in_ready=0, refresh=0, out_valid=0, out_pix=0, out_x=0, out_y=0, busy=0, frame_done=0.
  - Reset mid-frame abandons the frame: no frame_done pulse and no further out_valid.
- Handshake:
  - A window is accepted when in_valid && in_ready.
  - in_ready=1 only in RUN.
- State machine:
  - IDLE: when start=1, go to REFRESH.
  - REFRESH: refresh=1 for exactly this one cycle; input counters cleared; next state is RUN.
  - RUN: each accepted window increments the input column counter. The column counter wraps at WIDTH-1 to 0, and the row counter then increments. On accepting the window at (WIDTH-1, HEIGHT-1), go to FLUSH. in_valid=0 stalls counting with no timeout.
  - FLUSH: count LATENCY cycles after the last accept, then go to DONE. in_ready=0 and refresh is never asserted here, so in-flight results are not cleared.
  - DONE: frame_done=1 for one cycle. If start=1 in this cycle, go to REFRESH; else go to IDLE.
  - start is ignored outside IDLE and DONE.
- Output alignment:
  - The accept flag and input x/y enter a LATENCY-deep shift register.
  - At the tap, out_valid <= flag, out_x/out_y <= delayed coordinates, out_pix <= filt_pix or 0. This register stage adds one cycle: output appears LATENCY+1 cycles after accept.
  - Stalls (in_valid=0) produce bubbles, and these bubbles propagate as out_valid=0 at the same positions.
- Border mask: out_pix=0 when the delayed x==0, x==WIDTH-1, y==0 or y==HEIGHT-1. The window there is incomplete.
- Last output: the last out_valid occurs in the FLUSH cycle immediately before DONE. frame_done comes exactly one cycle after the last out_valid.
- Frame count: exactly WIDTH*HEIGHT out_valid pulses per frame.
- Back-to-back frames: start held high gives DONE -> REFRESH -> RUN with one refresh cycle between frames.

Optional Feature:
- Macro SOBEL_CTRL_EDGE_CNT_EN.
- Enabled:
  - Extra output edge_count, width X_W+Y_W.
  - Counts non-border out_valid pixels with filt_pix >= THRESH.
  - Cleared in REFRESH and by reset; frozen and readable from DONE until the next REFRESH.
- Disabled: no port and no counter logic.

Test Plan (WIDTH=4, HEIGHT=3, LATENCY=7):
- Reset behaviour: hold rst=0 for 3 cycles while start=1 -> all outputs 0, state IDLE; release rst -> refresh pulses 1 cycle later, then in_ready=1.
- Continuous frame: in_valid=1 constantly, filt_pix=8'hAA -> 12 out_valid pulses. Coordinates go (0,0)..(3,2) in raster order. out_pix=0xAA only at (1,1) and (2,1), 0 elsewhere. frame_done pulses 1 cycle after the (3,2) output.
- Stall: in_valid low for 5 cycles after the 6th accept -> matching 5-cycle out_valid gap. Same 12 coordinates; frame_done delayed by 5 cycles versus the previous test.
- Back-to-back frames: start held high -> refresh asserted only in the cycle after frame_done, never during RUN/FLUSH. The second frame's coordinates restart at (0,0).
- Mid-frame reset: rst=0 after 5 accepts -> out_valid drops to 0 within one cycle. No frame_done. The next frame starts clean at (0,0).
- Edge count (macro defined, THRESH=64): filt_pix=100 then 20 for the two interior outputs -> edge_count=1 at frame_done, and it holds until the next refresh.
